// File: rtl/emmc_rsp_receiver.sv
// eMMC host response receiver: waits for the device start bit after a command, then shifts in
// a 48-bit or 136-bit response and checks framing. The CRC7 check is built only when RSP_CRC_CHK_EN is defined.
module emmc_rsp_receiver #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 8
) (
  input  logic         mclk,
  input  logic         rstn,
  input  logic         rsp_arm,
  input  logic         rsp_long,
  input  logic         rsp_no_crc,
  input  logic         cmd_i,
  output logic         rsp_busy,
  output logic         rsp_valid,
  output logic [5:0]   rsp_index,
  output logic [31:0]  rsp_arg,
  output logic [119:0] rsp_cid,
  output logic         rsp_crc_err,
  output logic         rsp_frame_err,
  output logic         rsp_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] bit_num;
  logic [CNT_W-1:0] last_num;
  logic             long_q;
  logic             ferr_q;
  logic             ncr_expired;
  logic             last_bit;
  // The top 8 bits of an R2 frame never reach a field, so a 127-bit window is enough.
  logic [126:0]     sr_q;
  logic [127:0]     sr_nxt;

  assign sr_nxt      = {sr_q, cmd_i};
  assign bit_num     = bcnt_q + 1'b1;
  assign last_num    = long_q ? CNT_W'(136) : CNT_W'(48);
  assign ncr_expired = (tcnt_q == CNT_W'(NCR_MAX - 1));
  assign last_bit    = (state_q == S_RECV) && (bit_num == last_num);
  assign rsp_busy    = (state_q == S_WAIT) || (state_q == S_RECV);

  always_ff @(posedge mclk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rsp_arm) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cmd_i) begin
          state_d = S_RECV;
        end else if (ncr_expired) begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (bit_num == last_num) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rstn) begin
      tcnt_q        <= '0;
      bcnt_q        <= '0;
      long_q        <= 1'b0;
      ferr_q        <= 1'b0;
      sr_q          <= '0;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_index     <= '0;
      rsp_arg       <= '0;
      rsp_cid       <= '0;
      rsp_frame_err <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (state_q == S_DONE) begin
        rsp_frame_err <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (rsp_arm) begin
            long_q <= rsp_long;
            tcnt_q <= '0;
          end
        end
        S_WAIT: begin
          if (!cmd_i) begin
            // The start bit is a zero, so shifting it into a cleared register leaves it cleared.
            bcnt_q <= CNT_W'(1);
            sr_q   <= '0;
            ferr_q <= 1'b0;
          end else if (ncr_expired) begin
            rsp_timeout <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_RECV: begin
          sr_q   <= sr_nxt[126:0];
          bcnt_q <= bit_num;
          if ((bit_num == CNT_W'(2)) && cmd_i) begin
            ferr_q <= 1'b1;
          end
          if (last_bit) begin
            rsp_valid     <= 1'b1;
            rsp_frame_err <= ferr_q | ~cmd_i;
            if (long_q) begin
              rsp_index <= 6'h3F;
              rsp_arg   <= '0;
              rsp_cid   <= sr_nxt[127:8];
            end else begin
              rsp_index <= sr_nxt[45:40];
              rsp_arg   <= sr_nxt[39:8];
              rsp_cid   <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RSP_CRC_CHK_EN
  logic [6:0] crc_q;
  logic       no_crc_q;
  logic       crc_err_q;
  logic       crc_in_range;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // R2 covers only the CID bits (bit numbers 9..128); short frames cover bits 1..40.
  assign crc_in_range = long_q ? ((bit_num >= CNT_W'(9)) && (bit_num <= CNT_W'(128)))
                               : (bit_num <= CNT_W'(40));

  always_ff @(posedge mclk) begin
    if (!rstn) begin
      crc_q     <= '0;
      no_crc_q  <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      if (state_q == S_DONE) begin
        crc_err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (rsp_arm) begin
            no_crc_q <= rsp_no_crc;
          end
        end
        S_WAIT: begin
          if (!cmd_i) begin
            crc_q <= '0;
          end
        end
        S_RECV: begin
          if (crc_in_range) begin
            crc_q <= crc7_step(crc_q, cmd_i);
          end
          if (last_bit) begin
            crc_err_q <= ~no_crc_q && (sr_nxt[7:1] != crc_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_crc_err = crc_err_q;
`else
  logic unused_crc;
  assign unused_crc  = ^{rsp_no_crc, sr_nxt[7:1]};
  assign rsp_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_emmc_rsp_receiver.sv
// Directed bench for emmc_rsp_receiver: short/R2 responses, CRC and framing errors, timeout, reset abort.
module tb_emmc_rsp_receiver;

  logic         mclk = 1'b0;
  logic         rstn;
  logic         rsp_arm;
  logic         rsp_long;
  logic         rsp_no_crc;
  logic         cmd_i;
  logic         rsp_busy;
  logic         rsp_valid;
  logic [5:0]   rsp_index;
  logic [31:0]  rsp_arg;
  logic [119:0] rsp_cid;
  logic         rsp_crc_err;
  logic         rsp_frame_err;
  logic         rsp_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

`ifdef RSP_CRC_CHK_EN
  localparam logic EXP_CRC_ERR = 1'b1;
`else
  localparam logic EXP_CRC_ERR = 1'b0;
`endif

  emmc_rsp_receiver #(.NCR_MAX(64), .CNT_W(8)) dut (
    .mclk         (mclk),
    .rstn         (rstn),
    .rsp_arm      (rsp_arm),
    .rsp_long     (rsp_long),
    .rsp_no_crc   (rsp_no_crc),
    .cmd_i        (cmd_i),
    .rsp_busy     (rsp_busy),
    .rsp_valid    (rsp_valid),
    .rsp_index    (rsp_index),
    .rsp_arg      (rsp_arg),
    .rsp_cid      (rsp_cid),
    .rsp_crc_err  (rsp_crc_err),
    .rsp_frame_err(rsp_frame_err),
    .rsp_timeout  (rsp_timeout)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic arm(input logic lng, input logic nocrc);
    rsp_arm    = 1'b1;
    rsp_long   = lng;
    rsp_no_crc = nocrc;
    tick();
    rsp_arm    = 1'b0;
    rsp_long   = 1'b0;
    rsp_no_crc = 1'b0;
  endtask

  // Drives the low nb bits of f MSB first; early flags any valid/timeout before the last bit.
  task automatic send(input logic [135:0] f, input int nb, output logic early);
    early = 1'b0;
    for (int i = nb - 1; i >= 0; i--) begin
      cmd_i = f[i];
      tick();
      if (i != 0) early = early | rsp_valid | rsp_timeout;
    end
    cmd_i = 1'b1;
  endtask

  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  initial begin
    logic [135:0] r1_good;
    logic [135:0] r1_bad;
    logic [135:0] r3;
    logic [135:0] r2;
    logic [119:0] cid_v;
    logic         early;
    logic         seen;
    logic         busy_drop;

    r1_good = 136'h11_00000900_67;
    r1_bad  = 136'h11_00000901_67;
    r3      = 136'h3F_C0FF8080_FF;
    cid_v   = 120'h0123456789ABCDEF0123456789ABEF;
    r2      = {8'h3F, cid_v, crc7(cid_v), 1'b1};

    rstn = 1'b0; rsp_arm = 1'b0; rsp_long = 1'b0; rsp_no_crc = 1'b0; cmd_i = 1'b1;
    repeat (3) tick();
    chk("rst_busy", rsp_busy, 1'b0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_index", rsp_index, 6'd0);
    chk("rst_arg", rsp_arg, 32'd0);
    chk("rst_cid", rsp_cid, 120'd0);
    chk("rst_errs", {rsp_crc_err, rsp_frame_err, rsp_timeout}, 3'b000);
    rstn = 1'b1;
    tick();

    // R1 good, three idle-high cycles before the start bit
    arm(1'b0, 1'b0);
    chk("r1_busy_armed", rsp_busy, 1'b1);
    repeat (3) tick();
    send(r1_good, 48, early);
    chk("r1_no_early", early, 1'b0);
    chk("r1_valid", rsp_valid, 1'b1);
    chk("r1_index", rsp_index, 6'd17);
    chk("r1_arg", rsp_arg, 32'h0000_0900);
    chk("r1_cid", rsp_cid, 120'd0);
    chk("r1_crc_err", rsp_crc_err, 1'b0);
    chk("r1_frame_err", rsp_frame_err, 1'b0);
    tick();
    chk("r1_valid_pulse", rsp_valid, 1'b0);
    chk("r1_arg_held", rsp_arg, 32'h0000_0900);

    // CRC error: argument bit 0 flipped
    arm(1'b0, 1'b0);
    send(r1_bad, 48, early);
    chk("crc_valid", rsp_valid, 1'b1);
    chk("crc_err", rsp_crc_err, EXP_CRC_ERR);
    chk("crc_frame_err", rsp_frame_err, 1'b0);
    tick();
    chk("crc_err_cleared", rsp_crc_err, 1'b0);

    // R3: CRC field all ones, not checked
    arm(1'b0, 1'b1);
    send(r3, 48, early);
    chk("r3_valid", rsp_valid, 1'b1);
    chk("r3_index", rsp_index, 6'h3F);
    chk("r3_arg", rsp_arg, 32'hC0FF_8080);
    chk("r3_crc_err", rsp_crc_err, 1'b0);
    chk("r3_frame_err", rsp_frame_err, 1'b0);
    tick();

    // Timeout after exactly 64 high samples
    arm(1'b0, 1'b0);
    cmd_i = 1'b1;
    seen = 1'b0;
    busy_drop = 1'b0;
    repeat (63) begin
      tick();
      seen = seen | rsp_timeout | rsp_valid;
      busy_drop = busy_drop | ~rsp_busy;
    end
    chk("tout_not_early", seen, 1'b0);
    chk("tout_busy_held", busy_drop, 1'b0);
    tick();
    chk("tout_pulse", rsp_timeout, 1'b1);
    chk("tout_busy_fall", rsp_busy, 1'b0);
    chk("tout_no_valid", rsp_valid, 1'b0);
    tick();
    chk("tout_one_cycle", rsp_timeout, 1'b0);

    // Start bit on the 64th sample is accepted
    arm(1'b0, 1'b0);
    repeat (63) tick();
    send(r1_good, 48, early);
    chk("ncr64_no_early", early, 1'b0);
    chk("ncr64_valid", rsp_valid, 1'b1);
    chk("ncr64_index", rsp_index, 6'd17);
    tick();

    // R2 good
    arm(1'b1, 1'b0);
    send(r2, 136, early);
    chk("r2_valid", rsp_valid, 1'b1);
    chk("r2_index", rsp_index, 6'h3F);
    chk("r2_arg", rsp_arg, 32'd0);
    chk("r2_cid", rsp_cid, cid_v);
    chk("r2_errs", {rsp_crc_err, rsp_frame_err}, 2'b00);
    tick();

    // R2 with end bit 0
    r2[0] = 1'b0;
    arm(1'b1, 1'b0);
    send(r2, 136, early);
    chk("r2e_valid", rsp_valid, 1'b1);
    chk("r2e_frame_err", rsp_frame_err, 1'b1);
    chk("r2e_crc_err", rsp_crc_err, 1'b0);
    tick();
    chk("r2e_frame_cleared", rsp_frame_err, 1'b0);

    // Reset after 20 received bits aborts silently
    arm(1'b0, 1'b0);
    for (int i = 47; i >= 28; i--) begin
      cmd_i = r1_good[i];
      tick();
    end
    chk("abort_busy_pre", rsp_busy, 1'b1);
    cmd_i = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("abort_busy", rsp_busy, 1'b0);
    seen = 1'b0;
    repeat (80) begin
      tick();
      seen = seen | rsp_valid | rsp_timeout | rsp_busy;
    end
    chk("abort_no_pulse", seen, 1'b0);

    // Re-arm while waiting (with long=1) must be ignored
    arm(1'b0, 1'b0);
    tick();
    rsp_arm = 1'b1;
    rsp_long = 1'b1;
    tick();
    rsp_arm = 1'b0;
    rsp_long = 1'b0;
    send(r1_good, 48, early);
    chk("rearm_valid", rsp_valid, 1'b1);
    chk("rearm_index", rsp_index, 6'd17);
    chk("rearm_arg", rsp_arg, 32'h0000_0900);
    chk("rearm_errs", {rsp_crc_err, rsp_frame_err}, 2'b00);
    // Arm during DONE is ignored
    rsp_arm = 1'b1;
    tick();
    rsp_arm = 1'b0;
    chk("done_arm_ignored", rsp_busy, 1'b0);
    tick();
    chk("done_arm_idle", rsp_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
